// File: rtl/fp_square_seq_pkg.sv
// fp_square_seq_pkg: FP32 squarer state encodings, field constants and special-operand mapping
package fp_square_seq_pkg;
  localparam int MANT_W = 24;
  localparam int EXP_BIAS = 127;
  localparam logic [31:0] QNAN = 32'h7FC00000;
  localparam logic [31:0] POS_INF = 32'h7F800000;
  localparam logic [31:0] POS_ZERO = 32'h00000000;
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_UNPACK = 3'd1,
    S_MULT = 3'd2,
    S_NORM = 3'd3,
    S_ROUND = 3'd4,
    S_DONE = 3'd5
  } state_t;
  function automatic logic [31:0] special_result(input logic [7:0] exp, input logic frac_nz);
    return exp == 8'hFF ? (frac_nz ? QNAN : POS_INF) : POS_ZERO;
  endfunction
endpackage

// File: rtl/fp_square_seq_next_state.sv
// fp_square_seq_next_state: next-state logic of the squarer controller
module fp_square_seq_next_state
  import fp_square_seq_pkg::*;
(
  input  state_t cur_state,
  input  logic   special,
  input  logic   start,
  input  logic   last_iter,
  output state_t next_state
);
  always_comb begin
    next_state = S_IDLE;
    case (cur_state)
      S_IDLE:   next_state = start ? S_UNPACK : S_IDLE;
      S_UNPACK: next_state = special ? S_DONE : S_MULT;
      S_MULT:   next_state = last_iter ? S_NORM : S_MULT;
      S_NORM:   next_state = S_ROUND;
      S_ROUND:  next_state = S_DONE;
      default:  next_state = S_IDLE;
    endcase
  end
endmodule

// File: rtl/fp_square_seq.sv
// fp_square_seq: multi-cycle FP32 squarer using a shift-add 24x24 mantissa multiply
module fp_square_seq
  import fp_square_seq_pkg::*;
(
  input  logic        Clk_i,
  input  logic        nRst_i,
  input  logic        Start_i,
  input  logic [31:0] Data_i,
  output logic [31:0] Result_o,
  output logic        Done_o,
  output logic        Busy_o
);
  state_t state, state_nx;
  logic [30:0] x;
  logic [MANT_W-1:0] m;
  logic [2*MANT_W-1:0] p;
  logic [4:0] cnt;
  logic [22:0] man;
  logic g, s;
  logic signed [9:0] e, e_base, e_r;
  logic [23:0] man_up;
  logic [31:0] norm_res;
  logic special;
  logic sign_unused;
  assign sign_unused = Data_i[31];
  assign special = x[30:23] == 8'hFF || x[30:23] == 8'h00;
  assign e_base = $signed({1'b0, x[30:23], 1'b0}) - 10'(EXP_BIAS);
  assign man_up = {1'b0, man} + {23'b0, g & (s | man[0])};
  // a mantissa carry-out leaves man_up[22:0] all zero, so only the exponent moves
  assign e_r = e + $signed({9'b0, man_up[23]});
  assign norm_res = e_r >= 10'sd255 ? POS_INF : e_r <= 10'sd0 ? POS_ZERO : {1'b0, e_r[7:0], man_up[22:0]};
  fp_square_seq_next_state u_next_state (
    .cur_state (state),
    .special   (special),
    .start     (Start_i),
    .last_iter (cnt == 5'd23),
    .next_state(state_nx)
  );
  always_ff @(posedge Clk_i or negedge nRst_i) begin
    if (!nRst_i) begin
      state <= S_IDLE;
      Result_o <= '0;
      Done_o <= 1'b0;
      Busy_o <= 1'b0;
      x <= '0;
      m <= '0;
      p <= '0;
      cnt <= '0;
      man <= '0;
      g <= 1'b0;
      s <= 1'b0;
      e <= '0;
    end else begin
      state <= state_nx;
      Done_o <= state_nx == S_DONE;
      Busy_o <= state_nx != S_IDLE;
      if (state == S_IDLE && Start_i) x <= Data_i[30:0];
      if (state == S_UNPACK) begin
        m <= {1'b1, x[22:0]};
        p <= '0;
        cnt <= '0;
      end
      if (state == S_MULT) begin
        if (m[cnt]) p <= p + ({{MANT_W{1'b0}}, m} << cnt);
        cnt <= cnt + 5'd1;
      end
      if (state == S_NORM) begin
        man <= p[47] ? p[46:24] : p[45:23];
        g <= p[47] ? p[23] : p[22];
        s <= p[47] ? |p[22:0] : |p[21:0];
        e <= p[47] ? e_base + 10'sd1 : e_base;
      end
      if (state_nx == S_DONE)
        Result_o <= state == S_UNPACK ? special_result(x[30:23], |x[22:0]) : norm_res;
    end
  end
endmodule

// File: tb/tb_fp_square_seq.sv
// tb_fp_square_seq: scoreboard bench for the FP32 squarer against an integer RNE reference model
module tb_fp_square_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic [31:0] data = '0;
  logic [31:0] result;
  logic done, busy;
  int checks = 0;
  int errors = 0;
  longint cyc = 0;
  logic [31:0] exp_q[$];
  longint due_q[$];
  logic [31:0] exp_r;
  longint due_r;

  fp_square_seq dut (
    .Clk_i(clk), .nRst_i(rst_n), .Start_i(start), .Data_i(data),
    .Result_o(result), .Done_o(done), .Busy_o(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual %h required %h", name, act, req);
    end
  endtask

  function automatic logic is_special(input logic [31:0] v);
    return v[30:23] == 8'hFF || v[30:23] == 8'h00;
  endfunction

  // value-level model: exact 48-bit product, round-to-nearest-even on the discarded bits
  function automatic logic [31:0] model(input logic [31:0] v);
    longint unsigned mm, pp, q, rem, half;
    int ex, e2, sh;
    ex = int'(v[30:23]);
    if (ex == 255) return v[22:0] != 0 ? 32'h7FC00000 : 32'h7F800000;
    if (ex == 0) return 32'h0;
    mm = (64'd1 << 23) + 64'(v[22:0]);
    pp = mm * mm;
    e2 = 2 * ex - 127;
    sh = 23;
    if (pp >= (64'd1 << 47)) begin
      e2++;
      sh = 24;
    end
    q = pp >> sh;
    rem = pp & ((64'd1 << sh) - 1);
    half = 64'd1 << (sh - 1);
    if (rem > half || (rem == half && q[0])) q++;
    if (q == (64'd1 << 24)) begin
      q = q >> 1;
      e2++;
    end
    if (e2 >= 255) return 32'h7F800000;
    if (e2 <= 0) return 32'h0;
    return {1'b0, 8'(e2), q[22:0]};
  endfunction

  always @(negedge clk) begin
    if (rst_n && done) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done actual result %h required no pulse", result);
      end else begin
        exp_r = exp_q.pop_front();
        due_r = due_q.pop_front();
        check("result", result, exp_r);
        check("done_cycle", 32'(cyc), 32'(due_r));
      end
    end
  end

  task automatic issue(input logic [31:0] v, input logic [31:0] req);
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      checks++;
      errors++;
      $display("FAIL busy_timeout actual busy %b required 0", busy);
    end
    start = 1'b1;
    data = v;
    @(posedge clk);
    #1;
    exp_q.push_back(req);
    due_q.push_back(cyc + (is_special(v) ? 1 : 27));
    start = 1'b0;
    data = $urandom;
    check("busy_after_accept", {31'b0, busy}, 32'd1);
  endtask

  logic [31:0] dir_in[10] = '{32'h40000000, 32'h3FC00000, 32'hC0400000, 32'h3F800001, 32'h3F800000,
                              32'h7F000000, 32'h1F000000, 32'h7FC00001, 32'hFF800000, 32'h80000000};
  logic [31:0] dir_out[10] = '{32'h40800000, 32'h40100000, 32'h41100000, 32'h3F800002, 32'h3F800000,
                               32'h7F800000, 32'h00000000, 32'h7FC00000, 32'h7F800000, 32'h00000000};

  initial begin
    logic [31:0] v;
    int n;
    #12;
    check("reset_result", result, 32'h0);
    check("reset_done", {31'b0, done}, 32'd0);
    check("reset_busy", {31'b0, busy}, 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) issue(dir_in[i], dir_out[i]);
    // abort test: second start while busy ignored, reset mid-multiply drops the request
    issue(32'h40000000, 32'h40800000);
    repeat (6) @(negedge clk);
    start = 1'b1;
    data = 32'h40400000;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", {31'b0, busy}, 32'd0);
    check("abort_done", {31'b0, done}, 32'd0);
    check("abort_result", result, 32'h0);
    void'(exp_q.pop_back());
    void'(due_q.pop_back());
    @(negedge clk);
    rst_n = 1'b1;
    issue(32'h3FC00000, 32'h40100000);
    for (int i = 0; i < 150; i++) begin
      v = $urandom;
      case ($urandom_range(0, 7))
        0: v[30:23] = 8'hFF;
        1: v[30:23] = 8'h00;
        2: v[22:0] = 23'h0;
        default: v[30:23] = 8'($urandom_range(55, 200));
      endcase
      issue(v, model(v));
    end
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("pending_at_end", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
